pusha_popa_sequencer: RTL

PUSHA_POPA_SEQUENCER -- requirements
Module: pusha_popa_sequencer

---
 rtl/pusha_popa_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pusha_popa_sequencer.sv
// Multi-cycle PUSHA/POPA sequencer: walks the eight 16-bit registers through a
// registered-read register file and a handshaked stack memory port, then updates SP.
module pusha_popa_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_pop,
    input  logic [15:0] sp_in,
    output logic        busy,
    output logic        done,
    output logic [2:0]  rd_sel,
    input  logic [15:0] rd_val,
    output logic [2:0]  wr_sel,
    output logic [15:0] wr_val,
    output logic        wr_en,
    output logic        is_8_bit,
    output logic        mem_access,
    output logic        mem_wr_en,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wr_data,
    input  logic [15:0] mem_rd_data,
    input  logic        mem_ack
);

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_CAPTURE, MEM, REG_WR, SP_WR, DONE
    } state_t;

    state_t      state, state_nxt;
    logic        op_pop;
    logic [2:0]  index;
    logic [15:0] sp_orig;
    logic [15:0] data;

    // Slot k: push writes below SP at sp-2(k+1), pop reads upward from sp+2k (mod 2^16).
    function automatic logic [15:0] slot_addr(input logic pop, input logic [15:0] base,
                                              input logic [2:0] k);
        logic [15:0] off;
        off = {12'd0, k, 1'b0};
        return pop ? base + off : base - off - 16'd2;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start) state_nxt = is_pop ? MEM : RD_ISSUE;
            RD_ISSUE:   state_nxt = RD_CAPTURE;
            RD_CAPTURE: state_nxt = MEM;
            MEM: begin
                if (mem_ack) begin
                    if (!op_pop)          state_nxt = (index == 3'd7) ? SP_WR : RD_ISSUE;
                    else if (index == 3'd4) state_nxt = MEM;
                    else                  state_nxt = REG_WR;
                end
            end
            REG_WR:     state_nxt = (index == 3'd0) ? SP_WR : MEM;
            SP_WR:      state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_pop  <= 1'b0;
            index   <= 3'd0;
            sp_orig <= 16'd0;
            data    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_pop  <= is_pop;
                        sp_orig <= sp_in;
                        index   <= is_pop ? 3'd7 : 3'd0;
                    end
                end
                RD_CAPTURE: data <= (index == 3'd4) ? sp_orig : rd_val;
                MEM: begin
                    if (mem_ack) begin
                        if (op_pop) begin
                            data <= mem_rd_data;
                            // The popped SP slot has no REG_WR, so step past it here.
                            if (index == 3'd4) index <= index - 3'd1;
                        end else if (index != 3'd7) begin
                            index <= index + 3'd1;
                        end
                    end
                end
                REG_WR: if (index != 3'd0) index <= index - 3'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = 1'b0;
        rd_sel      = 3'd0;
        wr_sel      = 3'd0;
        wr_val      = 16'd0;
        wr_en       = 1'b0;
        mem_access  = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = 16'd0;
        mem_wr_data = 16'd0;
        case (state)
            RD_ISSUE: rd_sel = index;
            MEM: begin
                mem_access  = 1'b1;
                mem_wr_en   = !op_pop;
                mem_addr    = slot_addr(op_pop, sp_orig, op_pop ? ~index : index);
                mem_wr_data = op_pop ? 16'd0 : data;
            end
            REG_WR: begin
                wr_en  = 1'b1;
                wr_sel = index;
                wr_val = data;
            end
            SP_WR: begin
                wr_en  = 1'b1;
                wr_sel = 3'd4;
                wr_val = op_pop ? sp_orig + 16'd16 : sp_orig - 16'd16;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign is_8_bit = 1'b0;

endmodule
